alu_req_arbiter: RTL and testbench
==================================

ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the ALU.
REQ-002 Parameter DW, default 8: operand and result width.
REQ-003 wb_clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  in  NREQ*DW  operand A, requester i at bits [i*DW +: DW].
REQ-008 req_b  in  NREQ*DW  operand B, same packing as req_a.
REQ-009 req_sel  in  NREQ*2  op select, requester i at bits [i*2 +: 2].
REQ-010 rsp_valid  out  1  result available.
REQ-011 rsp_ready  in  1  consumer accepts result.
REQ-012 rsp_id  out  clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_result  out  DW  ALU result.
REQ-014 rsp_carry  out  1  carry/borrow flag.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 op_count  out  16  completed-response counter.

Function
REQ-017 FSM states: IDLE, EXEC, RESP.
REQ-018 IDLE transitions to EXEC in any cycle where some req_valid bit is high; it stays in IDLE otherwise.
REQ-019 Grant is round-robin: starting at rr_ptr, the first index with req_valid high wins.
REQ-020 In the IDLE grant cycle, req_ready[grant] is driven high combinationally and all other req_ready bits are low.
REQ-021 The handshake completes on req_valid & req_ready; on that edge, A, B, sel and the grant index are latched and rr_ptr becomes (grant+1) mod NREQ.
REQ-022 req_ready is low in EXEC and RESP.
REQ-023 EXEC lasts exactly one cycle: the ALU evaluates the latched operands, rsp_result, rsp_carry and rsp_id are registered, and the state goes to RESP.
REQ-024 ALU op 00: ADD, result = (A+B)[DW-1:0], carry = bit DW of the sum.
REQ-025 ALU op 01: SUB, result = (A-B) mod 2^DW, carry = 1 iff A<B (unsigned).
REQ-026 ALU op 10: AND, carry 0.
REQ-027 ALU op 11: OR, carry 0.
REQ-028 In RESP, rsp_valid is 1 and rsp_id, rsp_result and rsp_carry stay stable until rsp_ready is sampled high.
REQ-029 When rsp_ready is sampled high in RESP, the state goes to IDLE and op_count increments.
REQ-030 op_count wraps from 0xFFFF to 0.
REQ-031 Latency from accept edge to rsp_valid is 2 cycles; minimum issue interval is 3 cycles.
REQ-032 A requester that deasserts req_valid before it is granted loses nothing and causes no error.
REQ-033 A requester's inputs are ignored except in its grant cycle.
REQ-034 rsp_ready is ignored outside RESP.

Reset
REQ-035 When wb_rst_i is high at a clock edge, the next state is IDLE, rr_ptr=0, op_count=0, and the result/id/carry registers are 0.
REQ-036 During reset, req_ready=0, rsp_valid=0 and busy=0.
REQ-037 Reset asserted in EXEC or RESP aborts the in-flight operation with no response and no op_count increment.
REQ-038 Reset takes priority over every simultaneous event.

Structure
REQ-039 Shared package alu_arb_pkg holds the ALU op encodings (ADD, SUB, AND, OR), the FSM state enum and the op_count width constant.
REQ-040 The ALU is a separate combinational sub-module, alu8_core (inputs a, b, sel; outputs result, carry), instantiated once in alu_req_arbiter.
REQ-041 alu_req_arbiter contains all registers, the FSM and the round-robin pointer.

Verification
REQ-042 Reset, then requester 2 issues A=0xF0, B=0x20, sel=00 -> req_ready[2] high in the same cycle; rsp_valid 2 cycles after accept with result 0x10, carry 1, id 2; op_count=1 after rsp_ready.
REQ-043 All four requesters held valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with no requester granted twice before the others.
REQ-044 SUB A=0x05, B=0x07 -> result 0xFE, carry 1; AND 0xCC,0xAA -> 0x88, carry 0; OR 0xCC,0xAA -> 0xEE, carry 0.
REQ-045 rsp_ready held low for 5 cycles in RESP -> rsp_valid and outputs stable for all 5 cycles, req_ready all 0, busy 1.
REQ-046 wb_rst_i pulsed for one cycle while in EXEC -> next cycle IDLE, rsp_valid never asserts, op_count 0, rr_ptr 0.
REQ-047 Force 65536 completed responses -> op_count reads 0 after the last one.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared ALU-arbiter definitions: op encodings, FSM states, counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_arb_pkg;

  // ALU operation select encodings carried on req_sel.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  // Arbiter FSM: grant in IDLE, one ALU cycle in EXEC, hold result in RESP.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Width of the completed-response counter (wraps on overflow).
  localparam int OPCNT_W = 16;

endpackage

// File: rtl/alu8_core.sv
// Combinational ALU: ADD / SUB / AND / OR on two DW-bit operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the outputs.
//
// Ports:
//   a, b    operands
//   sel     operation (alu_op_e encoding)
//   result  DW-bit result (ADD/SUB wrap modulo 2^DW)
//   carry   ADD carry-out, SUB borrow (a < b), 0 for logic ops
module alu8_core
  import alu_arb_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    sel,
  output logic [DW-1:0] result,
  output logic          carry
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  // One extra bit holds the carry-out for ADD and the borrow for SUB:
  // the top bit of a zero-extended difference is set exactly when a < b.
  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (sel)
      OP_ADD: begin
        result = w_sum[DW-1:0];
        carry  = w_sum[DW];
      end
      OP_SUB: begin
        result = w_diff[DW-1:0];
        carry  = w_diff[DW];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters.
// Latency: grant cycle -> rsp_valid two cycles later; one issue per 3 cycles minimum.
// Backpressure: result held in RESP until rsp_ready; no grants issued meanwhile.
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready is one-hot)
//   req_a, req_b, req_sel        packed per-requester operands and op select
//   rsp_valid/rsp_ready          result handshake
//   rsp_id, rsp_result, rsp_carry  owner index, ALU result, carry/borrow
//   busy                         FSM not in IDLE
//   op_count                     completed-response counter (wraps)
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int DW   = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  input  logic [NREQ*2-1:0]    req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [DW-1:0]        rsp_result,
  output logic                 rsp_carry,
  output logic                 busy,
  output logic [OPCNT_W-1:0]   op_count
);

  arb_state_e         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_gnt_id;
  logic [DW-1:0]      r_a;
  logic [DW-1:0]      r_b;
  logic [1:0]         r_sel;
  logic [IW-1:0]      r_id;
  logic [DW-1:0]      r_result;
  logic               r_carry;
  logic [OPCNT_W-1:0] r_op_count;

  logic               w_any;
  logic [IW-1:0]      w_grant;
  logic [IW-1:0]      w_idx;
  logic [NREQ-1:0]    w_ready;
  logic               w_accept;
  logic [DW-1:0]      w_opa;
  logic [DW-1:0]      w_opb;
  logic [1:0]         w_opsel;
  logic [DW-1:0]      w_alu_res;
  logic               w_alu_carry;

  // Round-robin search: scan from r_rr_ptr upward (wrapping), first valid wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Operand mux for the granted lane plus the one-hot ready. Ready is
  // suppressed during reset so nothing is accepted on a reset edge.
  always_comb begin
    w_opa   = '0;
    w_opb   = '0;
    w_opsel = '0;
    w_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant == IW'(k)) begin
        w_opa   = req_a[k*DW +: DW];
        w_opb   = req_b[k*DW +: DW];
        w_opsel = req_sel[k*2 +: 2];
      end
    end
    if ((r_state == ST_IDLE) && w_any && !wb_rst_i) begin
      w_ready[w_grant] = 1'b1;
    end
  end

  assign w_accept = |(req_valid & w_ready);

  alu8_core #(.DW(DW)) u_alu (
    .a      (r_a),
    .b      (r_b),
    .sel    (r_sel),
    .result (w_alu_res),
    .carry  (w_alu_carry)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_sel      <= '0;
      r_id       <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_op_count <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= w_opa;
            r_b      <= w_opb;
            r_sel    <= w_opsel;
            r_gnt_id <= w_grant;
            r_rr_ptr <= (w_grant == IW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result <= w_alu_res;
          r_carry  <= w_alu_carry;
          r_id     <= r_gnt_id;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_op_count <= r_op_count + 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status outputs are forced low while reset is asserted.
  assign req_ready  = w_ready;
  assign rsp_valid  = (r_state == ST_RESP) && !wb_rst_i;
  assign busy       = (r_state != ST_IDLE) && !wb_rst_i;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_carry  = r_carry;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: transaction-level reference model
// compared every cycle, plus directed literal checks.
module tb_alu_req_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ*2-1:0]   req_sel;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [DW-1:0]       rsp_result;
  logic                rsp_carry;
  logic                busy;
  logic [15:0]         op_count;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_seq  = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy),
    .op_count   (op_count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic void alu_ref(input int a, input int b, input int s,
                                  output int r, output int c);
    int m;
    m = 1 << DW;
    case (s)
      0: begin r = (a + b) % m;     c = ((a + b) >= m) ? 1 : 0; end
      1: begin r = (a - b + m) % m; c = (a < b) ? 1 : 0;       end
      2: begin r = a & b;           c = 0;                     end
      default: begin r = a | b;     c = 0;                     end
    endcase
  endfunction

  // Advance to just after the next rising edge and scramble every lane's
  // operands, so only the granted lane's values in its grant cycle matter.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*DW +: DW] = DW'($urandom);
      req_b[k*DW +: DW] = DW'($urandom);
      req_sel[k*2 +: 2] = 2'($urandom);
    end
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_lane(input int r, input int a, input int b, input int s);
    req_a[r*DW +: DW] = DW'(a);
    req_b[r*DW +: DW] = DW'(b);
    req_sel[r*2 +: 2] = 2'(s);
  endtask

  // One full transaction from IDLE on requester r, rsp_ready held high.
  task automatic run_op(input int r, input int a, input int b, input int s,
                        input int er, input int ec);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[r] = 1'b1;
    step();
    req_valid = oh;
    set_lane(r, a, b, s);
    rsp_ready = 1'b1;
    samp();
    check("op_grant", req_ready, oh);
    step();
    req_valid = '0;
    step();
    samp();
    check("op_rsp_valid", rsp_valid, 1);
    check("op_result", rsp_result, er);
    check("op_carry", rsp_carry, ec);
    check("op_id", rsp_id, r);
    step();
  endtask

  // Cycle-by-cycle comparison against a transaction-level model.
  initial begin : compare
    int m_phase, m_rr, m_res, m_carry, m_id, m_cnt, g, ovr_seen;
    bit started;
    logic [NREQ-1:0] exp_rdy;
    started = 0; ovr_seen = 0;
    m_phase = 0; m_rr = 0; m_res = 0; m_carry = 0; m_id = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) started = 1;
      if (started) begin
        if (ovr_seq != ovr_seen) begin
          ovr_seen = ovr_seq;
          m_cnt = 16'hFFFF;
        end
        g = -1;
        if (!rst && m_phase == 0) begin
          for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
          end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("m_req_ready", req_ready, exp_rdy);
        check("m_rsp_valid", rsp_valid, (!rst && m_phase == 2) ? 1 : 0);
        check("m_busy", busy, (!rst && m_phase != 0) ? 1 : 0);
        if (!rst) check("m_op_count", op_count, m_cnt);
        if (!rst && m_phase == 2) begin
          check("m_rsp_id", rsp_id, m_id);
          check("m_rsp_result", rsp_result, m_res);
          check("m_rsp_carry", rsp_carry, m_carry);
        end
        if (rst) begin
          m_phase = 0; m_rr = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
          if (g >= 0) begin
            alu_ref(int'(req_a[g*DW +: DW]), int'(req_b[g*DW +: DW]),
                    int'(req_sel[g*2 +: 2]), m_res, m_carry);
            m_id = g;
            m_rr = (g + 1) % NREQ;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          m_phase = 2;
        end else if (rsp_ready) begin
          m_phase = 0;
          m_cnt = (m_cnt + 1) % 65536;
        end
      end
    end
  end

  initial begin : stim
    int gq[$];
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
    step();
    step();
    samp();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_carry", rsp_carry, 0);

    // Requester 2: 0xF0 + 0x20.
    step();
    rst = 1'b0;
    req_valid = 4'b0100;
    set_lane(2, 8'hF0, 8'h20, 0);
    rsp_ready = 1'b1;
    samp();
    check("add_ready_same_cycle", req_ready, 4'b0100);
    step();
    req_valid = '0;
    samp();
    check("add_exec_busy", busy, 1);
    check("add_exec_valid", rsp_valid, 0);
    step();
    samp();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_result", rsp_result, 8'h10);
    check("add_carry", rsp_carry, 1);
    check("add_id", rsp_id, 2);
    step();
    samp();
    check("add_op_count", op_count, 1);
    check("add_idle", busy, 0);

    run_op(0, 8'h05, 8'h07, 1, 8'hFE, 1);
    run_op(1, 8'hCC, 8'hAA, 2, 8'h88, 0);
    run_op(3, 8'hCC, 8'hAA, 3, 8'hEE, 0);
    run_op(1, 8'h12, 8'h34, 0, 8'h46, 0);
    samp();
    check("op_count_5", op_count, 5);

    // Consumer stalls five cycles in RESP while everyone requests.
    step();
    req_valid = 4'b0010;
    set_lane(1, 8'h80, 8'h80, 0);
    rsp_ready = 1'b0;
    samp();
    check("stall_grant", req_ready, 4'b0010);
    step();
    req_valid = '1;
    step();
    for (int i = 0; i < 5; i++) begin
      samp();
      check("stall_valid", rsp_valid, 1);
      check("stall_result", rsp_result, 8'h00);
      check("stall_carry", rsp_carry, 1);
      check("stall_id", rsp_id, 1);
      check("stall_ready", req_ready, 0);
      check("stall_busy", busy, 1);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    samp();
    check("stall_op_count", op_count, 6);

    // Reset pulse during EXEC aborts the operation.
    step();
    req_valid = 4'b1000;
    samp();
    check("abort_grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    rst = 1'b1;
    samp();
    check("abort_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    samp();
    check("abort_busy", busy, 0);
    check("abort_op_count", op_count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      samp();
      check("abort_no_rsp", rsp_valid, 0);
    end

    // All requesters valid: fairness from pointer 0.
    step();
    req_valid = '1;
    rsp_ready = 1'b1;
    gq.delete();
    for (int i = 0; i < 16; i++) begin
      samp();
      for (int k = 0; k < NREQ; k++) begin
        if (req_ready[k]) gq.push_back(k);
      end
      step();
    end
    req_valid = '0;
    check("rr_grant_count_ge5", (gq.size() >= 5) ? 1 : 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) check("rr_order", gq[i], i % NREQ);
    end

    // Random traffic with occasional resets and consumer stalls.
    for (int c = 0; c < 3000; c++) begin
      step();
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      rst = ($urandom_range(0, 199) == 0);
    end

    // Counter wrap: preload to 0xFFFF, complete one response.
    step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    force dut.r_op_count = 16'hFFFF;
    ovr_seq++;
    #2;
    release dut.r_op_count;
    run_op(2, 8'hFF, 8'h01, 0, 8'h00, 1);
    samp();
    check("op_count_wrap", op_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
